ysyx_23060332_seq: RTL and testbench
====================================

YSYX_23060332_SEQ -- requirements
Module: ysyx_23060332_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, address of the first fetch after reset.
REQ-002 Parameter TIMEOUT, default 8'd255, maximum WAIT cycles allowed before a fetch response arrives.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  leave IDLE and begin fetching; sampled in IDLE only.
REQ-006 ifu_req_valid  output  1  fetch request valid.
REQ-007 ifu_req_ready  input  1  fetch request accepted.
REQ-008 ifu_addr  output  32  fetch address; equals pc.
REQ-009 ifu_rsp_valid  input  1  fetch response valid; one-cycle pulse.
REQ-010 ifu_rsp_data  input  32  fetched instruction word.
REQ-011 inst  output  32  registered instruction driven to the decoder.
REQ-012 dec_addi  input  1  decoder flags inst as addi (opcode 0010011, funct3 000).
REQ-013 dec_ebreak  input  1  decoder flags inst as ebreak (opcode 1110011, imm 12'h001).
REQ-014 rf_wen  output  1  register-file write enable; one-cycle pulse.
REQ-015 pc  output  32  current program counter.
REQ-016 retired  output  32  count of completed addi instructions.
REQ-017 halted  output  1  sequencer is in HALT.
REQ-018 halt_cause  output  2  00 none, 01 ebreak, 10 illegal, 11 fetch timeout.

Function
REQ-019 The block SHALL implement six states: IDLE, FETCH, WAIT, DECODE, EXEC, HALT.
REQ-020 IDLE->FETCH when start=1; otherwise remain in IDLE.
REQ-021 FETCH: ifu_req_valid=1, with ifu_addr held stable until ifu_req_ready=1; on handshake, go to WAIT and clear the timeout counter.
REQ-022 WAIT: on ifu_rsp_valid, latch ifu_rsp_data into inst and go to DECODE; otherwise increment the 8-bit counter; when the counter equals TIMEOUT, go to HALT with halt_cause=11.
REQ-023 A response arriving on the same cycle the counter reaches TIMEOUT SHALL win: no timeout is taken.
REQ-024 ifu_rsp_valid outside WAIT SHALL be ignored; inst is unchanged.
REQ-025 DECODE SHALL last exactly one cycle so the combinational decoder settles, then go to EXEC.
REQ-026 EXEC with dec_addi: rf_wen=1 for that cycle, pc<=pc+4, retired<=retired+1, then FETCH.
REQ-027 EXEC with dec_ebreak: rf_wen=0, pc unchanged, halt_cause=01, then HALT.
REQ-028 EXEC with neither flag: halt_cause=10, then HALT; if both flags are set, dec_ebreak SHALL take priority.
REQ-029 HALT SHALL be absorbing; only rst_n leaves it; halted=1 in HALT only.
REQ-030 pc addition wraps modulo 2^32 (32'hFFFF_FFFC -> 0); retired wraps at 2^32.
REQ-031 Steady-state throughput SHALL be one addi per 4 cycles with zero-wait handshakes (FETCH, WAIT, DECODE, EXEC).
REQ-032 rf_wen SHALL never be asserted outside EXEC.
REQ-033 ifu_req_valid SHALL never be asserted outside FETCH.

Reset
REQ-034 Asserting rst_n=0 in any state SHALL immediately force: state IDLE, pc=RESET_PC, inst=0, retired=0, halt_cause=00, counter=0, all strobes 0.
REQ-035 Reset mid-fetch SHALL drop ifu_req_valid asynchronously; a response arriving after release is ignored (REQ-024).
REQ-036 Reset deassertion requires no synchronizer inside the block; the first rising edge after release evaluates IDLE.

Structure
REQ-037 A shared package holds the state encoding (3-bit enum), halt_cause codes, and the opcode/funct3/imm constants used by the decoder.
REQ-038 One sub-module, ysyx_23060332_seq_tmo (8-bit timeout counter with clear, enable and hit outputs), is natural; everything else is a single FSM plus datapath registers.

Verification
REQ-039 Reset, start=1, ready and response both zero-latency, 3x addi (32'h00100093) then ebreak (32'h00100073) -> 3 rf_wen pulses 4 cycles apart; pc=0x8000000C; retired=3; halted=1; halt_cause=01.
REQ-040 ifu_req_ready held low for 5 cycles in FETCH -> ifu_addr stable for 6 cycles; exactly one handshake.
REQ-041 No response for 255 WAIT cycles -> HALT with halt_cause=11; response exactly on the 255th cycle -> DECODE instead.
REQ-042 Fetch returns 32'h00000033 (neither flag set) -> halt_cause=10; no rf_wen; pc unchanged.
REQ-043 rst_n pulsed low in WAIT and in HALT -> all outputs at reset values the same cycle; a stray ifu_rsp_valid in IDLE leaves inst=0.
REQ-044 RESET_PC=32'hFFFF_FFFC with one addi -> pc wraps to 0; the next fetch address is 0.

Source files
------------

// File: rtl/ysyx_23060332_seq_pkg.sv
// Shared definitions for the ysyx_23060332 instruction sequencer:
// state encoding, halt cause codes and the RV32I fields the decoder keys on.
package ysyx_23060332_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_EBREAK  = 2'b01,
        CAUSE_ILLEGAL = 2'b10,
        CAUSE_TIMEOUT = 2'b11
    } halt_cause_t;

    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0]  F3_ADDI    = 3'b000;
    localparam logic [11:0] IMM_EBREAK = 12'h001;
    localparam logic [31:0] INST_BYTES = 32'd4;

    // Reference decode rules for the external decoder feeding dec_addi.
    function automatic logic is_addi(input logic [31:0] word);
        return (word[6:0] == OPC_OP_IMM) && (word[14:12] == F3_ADDI);
    endfunction

    // Reference decode rules for the external decoder feeding dec_ebreak.
    function automatic logic is_ebreak(input logic [31:0] word);
        return (word[6:0] == OPC_SYSTEM) && (word[31:20] == IMM_EBREAK);
    endfunction

endpackage

// File: rtl/ysyx_23060332_seq_if.sv
// Instruction-fetch channel: a valid/ready request carrying the address,
// followed by a single-cycle response pulse carrying the instruction word.
interface ysyx_23060332_seq_if;

    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;

    // Sequencer side.
    modport master (
        output ifu_req_valid,
        output ifu_addr,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_data
    );

    // Instruction memory side.
    modport slave (
        input  ifu_req_valid,
        input  ifu_addr,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_data
    );

endinterface

// File: rtl/ysyx_23060332_seq_tmo.sv
// Fetch-response watchdog: 8-bit counter of WAIT cycles without a response.
// hit flags the increment that makes the count reach TIMEOUT.
module ysyx_23060332_seq_tmo #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [7:0] cnt;

    // Count idle WAIT cycles; cleared at every request handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of block ordering.
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign hit = en && (cnt == TIMEOUT - 8'd1);

endmodule

// File: rtl/ysyx_23060332_seq.sv
// Minimal instruction sequencer: fetches words from RESET_PC onward,
// retires addi, halts on ebreak, an illegal word or a fetch timeout.
module ysyx_23060332_seq
    import ysyx_23060332_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    ysyx_23060332_seq_if.master       ifu,
    output logic [31:0]               inst,
    input  logic                      dec_addi,
    input  logic                      dec_ebreak,
    output logic                      rf_wen,
    output logic [31:0]               pc,
    output logic [31:0]               retired,
    output logic                      halted,
    output logic [1:0]                halt_cause
);

    state_t      state;
    state_t      state_nxt;
    halt_cause_t cause_q;
    halt_cause_t cause_nxt;
    logic        req_valid;
    logic        tmo_clr;
    logic        tmo_en;
    logic        tmo_hit;
    logic        inst_ld;
    logic        retire;
    logic        cause_ld;

    ysyx_23060332_seq_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmo_clr),
        .en    (tmo_en),
        .hit   (tmo_hit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a response beats a same-cycle timeout, ebreak beats addi.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  if (ifu.ifu_req_ready) state_nxt = S_WAIT;
            S_WAIT: begin
                if (ifu.ifu_rsp_valid) begin
                    state_nxt = S_DECODE;
                end else if (tmo_hit) begin
                    state_nxt = S_HALT;
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (dec_ebreak) begin
                    state_nxt = S_HALT;
                end else if (dec_addi) begin
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Per-state strobes and datapath load enables.
    always_comb begin
        req_valid = 1'b0;
        rf_wen    = 1'b0;
        halted    = 1'b0;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        inst_ld   = 1'b0;
        retire    = 1'b0;
        cause_ld  = 1'b0;
        cause_nxt = CAUSE_NONE;
        case (state)
            S_FETCH: begin
                req_valid = 1'b1;
                tmo_clr   = ifu.ifu_req_ready;
            end
            S_WAIT: begin
                inst_ld = ifu.ifu_rsp_valid;
                tmo_en  = !ifu.ifu_rsp_valid;
                if (tmo_hit) begin
                    cause_ld  = 1'b1;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_EXEC: begin
                if (dec_ebreak) begin
                    cause_ld  = 1'b1;
                    cause_nxt = CAUSE_EBREAK;
                end else if (dec_addi) begin
                    rf_wen = 1'b1;
                    retire = 1'b1;
                end else begin
                    cause_ld  = 1'b1;
                    cause_nxt = CAUSE_ILLEGAL;
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // Architectural registers: pc, fetched word, retire count, halt cause.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: inst is reset too, not just the control state, because the
        // decoder looks at it combinationally from the very first cycle.
        if (!rst_n) begin
            pc      <= RESET_PC;
            inst    <= 32'd0;
            retired <= 32'd0;
            cause_q <= CAUSE_NONE;
        end else begin
            if (inst_ld) begin
                inst <= ifu.ifu_rsp_data;
            end
            if (retire) begin
                pc      <= pc + INST_BYTES;
                retired <= retired + 32'd1;
            end
            if (cause_ld) begin
                cause_q <= cause_nxt;
            end
        end
    end

    assign ifu.ifu_req_valid = req_valid;
    assign ifu.ifu_addr      = pc;
    assign halt_cause        = cause_q;

endmodule

// File: tb/tb_ysyx_23060332_seq.sv
// Self-checking bench for ysyx_23060332_seq. Two instances (different
// RESET_PC) share the same stimulus; a per-instruction timing model builds
// the expected cycle-by-cycle outputs, compared on every falling edge.
module tb_ysyx_23060332_seq;

    localparam int          TMO    = 255;
    localparam int          MAXC   = 4096;
    localparam logic [31:0] BASE_A = 32'h8000_0000;
    localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;
    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef struct {
        logic [31:0] word;
        int          rd;   // cycles ready is held low in FETCH
        int          wd;   // WAIT cycles before the response (>= TMO: none)
    } ins_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic        rsp = 1'b0;
    logic [31:0] rdata = 32'd0;

    logic [31:0] inst_a, inst_b, pc_a, pc_b, ret_a, ret_b;
    logic        wen_a, wen_b, halt_a, halt_b;
    logic [1:0]  cause_a, cause_b;
    logic        dec_addi_a, dec_addi_b, dec_ebreak_a, dec_ebreak_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_23060332_seq_if ifu_a ();
    ysyx_23060332_seq_if ifu_b ();

    assign ifu_a.ifu_req_ready = ready;
    assign ifu_a.ifu_rsp_valid = rsp;
    assign ifu_a.ifu_rsp_data  = rdata;
    assign ifu_b.ifu_req_ready = ready;
    assign ifu_b.ifu_rsp_valid = rsp;
    assign ifu_b.ifu_rsp_data  = rdata;

    // Decoder rules written out independently of the design package.
    function automatic bit f_addi(input logic [31:0] w);
        return (w[6:0] == 7'b0010011) && (w[14:12] == 3'b000);
    endfunction

    function automatic bit f_ebreak(input logic [31:0] w);
        return (w[6:0] == 7'b1110011) && (w[31:20] == 12'h001);
    endfunction

    assign dec_addi_a   = f_addi(inst_a);
    assign dec_ebreak_a = f_ebreak(inst_a);
    assign dec_addi_b   = f_addi(inst_b);
    assign dec_ebreak_b = f_ebreak(inst_b);

    ysyx_23060332_seq #(.RESET_PC(BASE_A), .TIMEOUT(8'd255)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .ifu(ifu_a),
        .inst(inst_a), .dec_addi(dec_addi_a), .dec_ebreak(dec_ebreak_a),
        .rf_wen(wen_a), .pc(pc_a), .retired(ret_a),
        .halted(halt_a), .halt_cause(cause_a)
    );

    ysyx_23060332_seq #(.RESET_PC(BASE_B), .TIMEOUT(8'd255)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .ifu(ifu_b),
        .inst(inst_b), .dec_addi(dec_addi_b), .dec_ebreak(dec_ebreak_b),
        .rf_wen(wen_b), .pc(pc_b), .retired(ret_b),
        .halted(halt_b), .halt_cause(cause_b)
    );

    // Stimulus and expectation timeline, one entry per clock cycle.
    logic        t_start [MAXC];
    logic        t_ready [MAXC];
    logic        t_rsp   [MAXC];
    logic [31:0] t_data  [MAXC];
    logic        e_req   [MAXC];
    logic        e_wen   [MAXC];
    logic [31:0] e_off   [MAXC];
    logic [31:0] e_ret   [MAXC];
    logic [31:0] e_ins   [MAXC];
    logic        e_halt  [MAXC];
    logic [1:0]  e_cause [MAXC];

    ins_t        prog[$];
    logic [31:0] m_off, m_ret, m_ins;
    logic [1:0]  m_cause;
    logic        m_halt;
    int          long_wait_c, long_fetch_c, halt_c;
    int          cur = 0;
    bit          chk_en = 1'b0;
    int          hs_cnt = 0;
    int          wen_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit rb();
        return $urandom_range(3) == 0;
    endfunction

    task automatic add(input logic [31:0] w, input int r, input int d);
        prog.push_back('{word: w, rd: r, wd: d});
    endtask

    task automatic put(input int c, input bit st, input bit rdy, input bit rv,
                       input logic [31:0] dat, input bit req, input bit wen);
        t_start[c] = st;     t_ready[c] = rdy;   t_rsp[c] = rv;    t_data[c] = dat;
        e_req[c]   = req;    e_wen[c]   = wen;   e_off[c] = m_off; e_ret[c]  = m_ret;
        e_ins[c]   = m_ins;  e_halt[c]  = m_halt; e_cause[c] = m_cause;
    endtask

    // Instruction-level timing: fetch (rd+1), wait (wd+1), decode 1, exec 1.
    task automatic build(input int n_idle, output int n_cyc);
        int c;
        c = 0;
        m_off = 0; m_ret = 0; m_ins = 0; m_cause = 2'b00; m_halt = 1'b0;
        long_wait_c = -1; long_fetch_c = -1; halt_c = -1;
        for (int i = 0; i < n_idle; i++) begin
            put(c, 1'b0, rb(), rb(), $urandom, 1'b0, 1'b0); c++;
        end
        put(c, 1'b1, rb(), rb(), $urandom, 1'b0, 1'b0); c++;
        foreach (prog[k]) begin
            if (prog[k].rd >= 3 && long_fetch_c < 0) long_fetch_c = c;
            for (int i = 0; i <= prog[k].rd; i++) begin
                put(c, rb(), i == prog[k].rd, rb(), $urandom, 1'b1, 1'b0); c++;
            end
            if (prog[k].wd >= 20 && long_wait_c < 0) long_wait_c = c;
            if (prog[k].wd >= TMO) begin
                for (int i = 0; i < TMO; i++) begin
                    put(c, rb(), rb(), 1'b0, $urandom, 1'b0, 1'b0); c++;
                end
                m_cause = 2'b11;
                break;
            end
            for (int i = 0; i < prog[k].wd; i++) begin
                put(c, rb(), rb(), 1'b0, $urandom, 1'b0, 1'b0); c++;
            end
            put(c, rb(), rb(), 1'b1, prog[k].word, 1'b0, 1'b0); c++;
            m_ins = prog[k].word;
            put(c, rb(), rb(), rb(), $urandom, 1'b0, 1'b0); c++;
            put(c, rb(), rb(), rb(), $urandom, 1'b0, f_addi(m_ins) && !f_ebreak(m_ins)); c++;
            if (f_ebreak(m_ins)) begin m_cause = 2'b01; break; end
            if (!f_addi(m_ins))  begin m_cause = 2'b10; break; end
            m_off = m_off + 32'd4;
            m_ret = m_ret + 32'd1;
        end
        m_halt = 1'b1;
        halt_c = c;
        for (int i = 0; i < 6; i++) begin
            put(c, rb(), rb(), rb(), $urandom, 1'b0, 1'b0); c++;
        end
        n_cyc = c;
    endtask

    task automatic check_idle_outputs(input string tag, input bit inst_zero);
        check({tag, ".a.req_valid"}, 32'(ifu_a.ifu_req_valid), 32'd0);
        check({tag, ".b.req_valid"}, 32'(ifu_b.ifu_req_valid), 32'd0);
        check({tag, ".a.rf_wen"},    32'(wen_a),   32'd0);
        check({tag, ".a.pc"},        pc_a,         BASE_A);
        check({tag, ".b.pc"},        pc_b,         BASE_B);
        check({tag, ".a.retired"},   ret_a,        32'd0);
        check({tag, ".a.halted"},    32'(halt_a),  32'd0);
        check({tag, ".a.cause"},     32'(cause_a), 32'd0);
        if (inst_zero) begin
            check({tag, ".a.inst"}, inst_a, 32'd0);
            check({tag, ".b.inst"}, inst_b, 32'd0);
        end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_n = 1'b0; start = 1'b0; ready = 1'b0; rsp = 1'b0; rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // abort: 0 none, 1 reset in a long WAIT, 2 reset in HALT, 3 reset in a stalled FETCH.
    task automatic run_prog(input int n_idle, input int abort);
        int n;
        int abort_c;
        build(n_idle, n);
        abort_c = (abort == 1) ? long_wait_c + 10 :
                  (abort == 2) ? halt_c + 2 :
                  (abort == 3) ? long_fetch_c + 2 : -1;
        do_reset();
        hs_cnt = 0;
        wen_q.delete();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            start = t_start[c]; ready = t_ready[c]; rsp = t_rsp[c]; rdata = t_data[c];
            if (c == abort_c) begin
                chk_en = 1'b0;
                #2 rst_n = 1'b0;
                #1 check_idle_outputs("async_rst", 1'b1);
                @(negedge clk);
                rst_n = 1'b1; start = 1'b0; ready = 1'b0;
                rsp = 1'b1; rdata = 32'hDEAD_BEEF;
                repeat (3) begin
                    @(negedge clk);
                    check_idle_outputs("stray_rsp_idle", 1'b1);
                end
                rsp = 1'b0;
                return;
            end
            cur = c;
            chk_en = 1'b1;
        end
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        start = 1'b0; ready = 1'b0; rsp = 1'b0;
    endtask

    // Every-cycle comparison of both instances against the timeline.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a.req_valid", 32'(ifu_a.ifu_req_valid), 32'(e_req[cur]));
            check("b.req_valid", 32'(ifu_b.ifu_req_valid), 32'(e_req[cur]));
            check("a.ifu_addr",  ifu_a.ifu_addr, BASE_A + e_off[cur]);
            check("b.ifu_addr",  ifu_b.ifu_addr, BASE_B + e_off[cur]);
            check("a.pc",        pc_a,           BASE_A + e_off[cur]);
            check("b.pc",        pc_b,           BASE_B + e_off[cur]);
            check("a.rf_wen",    32'(wen_a),     32'(e_wen[cur]));
            check("b.rf_wen",    32'(wen_b),     32'(e_wen[cur]));
            check("a.retired",   ret_a,          e_ret[cur]);
            check("b.retired",   ret_b,          e_ret[cur]);
            check("a.inst",      inst_a,         e_ins[cur]);
            check("b.inst",      inst_b,         e_ins[cur]);
            check("a.halted",    32'(halt_a),    32'(e_halt[cur]));
            check("b.halted",    32'(halt_b),    32'(e_halt[cur]));
            check("a.halt_cause", 32'(cause_a),  32'(e_cause[cur]));
            check("b.halt_cause", 32'(cause_b),  32'(e_cause[cur]));
            if (ifu_a.ifu_req_valid && ifu_a.ifu_req_ready) hs_cnt++;
            if (wen_a) wen_q.push_back(cur);
        end
    end

    task automatic rand_prog();
        int          len;
        logic [31:0] w;
        int          r, d;
        prog.delete();
        len = $urandom_range(8, 2);
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            case ($urandom_range(9))
                0:       w = EBREAK;
                1: begin w[6:0] = 7'b0110011; end
                default: begin w[6:0] = 7'b0010011; w[14:12] = 3'b000; end
            endcase
            r = (rb()) ? $urandom_range(6) : 0;
            d = (rb()) ? $urandom_range(6) : 0;
            case ($urandom_range(24))
                0:       d = TMO - 1;
                1:       d = TMO - 2;
                2:       d = TMO;
                default: ;
            endcase
            add(w, r, d);
        end
        add(EBREAK, 0, 0);
    endtask

    initial begin
        // Three zero-latency addi then ebreak.
        prog.delete();
        add(ADDI, 0, 0); add(ADDI, 0, 0); add(ADDI, 0, 0); add(EBREAK, 0, 0);
        run_prog(2, 0);
        check("basic.pc_a",       pc_a,  32'h8000_000C);
        check("basic.pc_b",       pc_b,  32'h0000_0008);
        check("basic.retired",    ret_a, 32'd3);
        check("basic.halted",     32'(halt_a),  32'd1);
        check("basic.cause",      32'(cause_a), 32'd1);
        check("basic.wen_pulses", wen_q.size(), 32'd3);
        if (wen_q.size() == 3) begin
            check("basic.wen_gap0", wen_q[1] - wen_q[0], 32'd4);
            check("basic.wen_gap1", wen_q[2] - wen_q[1], 32'd4);
        end

        // Ready held low five cycles: one handshake per fetch.
        prog.delete();
        add(ADDI, 5, 0); add(EBREAK, 0, 0);
        run_prog(1, 0);
        check("stall.handshakes", hs_cnt, 32'd2);
        check("stall.pc_a",       pc_a,   32'h8000_0004);

        // No response for TIMEOUT cycles.
        prog.delete();
        add(ADDI, 0, TMO);
        run_prog(0, 0);
        check("tmo.cause",   32'(cause_a), 32'd3);
        check("tmo.halted",  32'(halt_a),  32'd1);
        check("tmo.pc_a",    pc_a,         BASE_A);
        check("tmo.retired", ret_a,        32'd0);

        // Response on the last permitted WAIT cycle wins.
        prog.delete();
        add(ADDI, 0, TMO - 1); add(EBREAK, 0, 0);
        run_prog(0, 0);
        check("tmo_edge.cause",   32'(cause_a), 32'd1);
        check("tmo_edge.retired", ret_a,        32'd1);

        // Neither flag set.
        prog.delete();
        add(32'h0000_0033, 0, 0);
        run_prog(1, 0);
        check("illegal.cause", 32'(cause_a), 32'd2);
        check("illegal.wen",   wen_q.size(), 32'd0);
        check("illegal.pc_a",  pc_a,         BASE_A);

        // Wrap from 0xFFFF_FFFC.
        prog.delete();
        add(ADDI, 0, 0); add(EBREAK, 0, 0);
        run_prog(0, 0);
        check("wrap.pc_b", pc_b, 32'h0000_0000);

        // Asynchronous reset in WAIT, in HALT and in a stalled FETCH.
        prog.delete();
        add(ADDI, 0, 0); add(ADDI, 1, 60); add(EBREAK, 0, 0);
        run_prog(1, 1);
        prog.delete();
        add(ADDI, 0, 1); add(EBREAK, 0, 0);
        run_prog(1, 2);
        prog.delete();
        add(ADDI, 0, 0); add(ADDI, 5, 0); add(EBREAK, 0, 0);
        run_prog(0, 3);

        // Randomized programs.
        for (int i = 0; i < 10; i++) begin
            rand_prog();
            run_prog($urandom_range(3), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
